// File: rtl/dotmtx_seq_pkg.sv
// Shared constants for the dot-matrix frame sequencer: FSM encoding, AXI response
// codes and the offset of the high data word.
package dotmtx_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WR_LO = 3'd2;
  localparam logic [2:0] ST_B_LO  = 3'd3;
  localparam logic [2:0] ST_WR_HI = 3'd4;
  localparam logic [2:0] ST_B_HI  = 3'd5;
  localparam logic [2:0] ST_WAIT  = 3'd6;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [31:0] HI_OFFSET = 32'd4;

endpackage

// File: rtl/dotmtx_seq.sv
// Autonomous frame sequencer: plays a looped 64-bit frame store into the dot-matrix
// peripheral as two single-beat AXI4-Lite writes (low word, then high word) per frame.
module dotmtx_seq
  import dotmtx_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NFRAMES   = 8,
  parameter int unsigned PERIOD    = 1_000_000
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       en,
  input  logic [$clog2(NFRAMES):0]   nframes_cfg,
  input  logic                       fb_we,
  input  logic [$clog2(NFRAMES)-1:0] fb_addr,
  input  logic [63:0]                fb_wdata,
  output logic                       busy,
  output logic [$clog2(NFRAMES)-1:0] cur_frame,
  output logic                       err,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [31:0]                m_axi_awaddr,
  output logic [2:0]                 m_axi_awprot,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  output logic [31:0]                m_axi_wdata,
  output logic [3:0]                 m_axi_wstrb,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready,
  input  logic [1:0]                 m_axi_bresp
);

  localparam int unsigned IW        = $clog2(NFRAMES);
  localparam logic [IW:0] NF_MAX    = (IW+1)'(NFRAMES);
  localparam logic [31:0] PERIOD_M1 = 32'(PERIOD - 1);

  logic [63:0]   store_q [NFRAMES];
  logic [2:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] cur_q, cur_d;
  logic [63:0]   shadow_q, shadow_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   awaddr_q, awaddr_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          err_q, err_d;

  logic [IW:0]   loop_len;
  logic [IW:0]   idx_inc;
  logic [IW-1:0] idx_wrap;
  logic          half_hi;

  always_comb begin
    if (nframes_cfg == '0) begin
      loop_len = (IW+1)'(1);
    end else if (nframes_cfg > NF_MAX) begin
      loop_len = NF_MAX;
    end else begin
      loop_len = nframes_cfg;
    end
  end

  assign idx_inc  = {1'b0, idx_q} + (IW+1)'(1);
  assign idx_wrap = (idx_inc >= loop_len) ? '0 : idx_inc[IW-1:0];

  assign half_hi = (state_q == ST_WR_HI) || (state_q == ST_B_HI);

  assign busy          = (state_q != ST_IDLE);
  assign cur_frame     = cur_q;
  assign err           = err_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = half_hi ? shadow_q[63:32] : shadow_q[31:0];
  assign m_axi_wstrb   = 4'b1111;
  assign m_axi_bready  = (state_q == ST_B_LO) || (state_q == ST_B_HI);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cur_d     = cur_q;
    shadow_d  = shadow_q;
    cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    awaddr_d  = awaddr_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    err_d     = err_q;

    if (m_axi_bready && m_axi_bvalid && (m_axi_bresp != RESP_OKAY)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shadow_d  = store_q[idx_q];
        cur_d     = idx_q;
        // The LOAD cycle itself counts as cycle 0 of the period.
        cnt_d     = 32'd1;
        awaddr_d  = BASE_ADDR;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        state_d   = ST_WR_LO;
      end
      ST_WR_LO, ST_WR_HI: begin
        if (m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
          state_d = (state_q == ST_WR_LO) ? ST_B_LO : ST_B_HI;
        end
      end
      ST_B_LO: begin
        if (m_axi_bvalid) begin
          awaddr_d  = BASE_ADDR + HI_OFFSET;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ST_WR_HI;
        end
      end
      ST_B_HI: begin
        if (m_axi_bvalid) begin
          idx_d   = idx_wrap;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // >= lets an overrunning transfer start the next frame straight away.
        if (!en) begin
          state_d = ST_IDLE;
        end else if (cnt_q >= PERIOD_M1) begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cur_q     <= '0;
      shadow_q  <= '0;
      cnt_q     <= '0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cur_q     <= cur_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(NFRAMES); i++) store_q[i] <= '0;
    end else if (fb_we) begin
      store_q[fb_addr] <= fb_wdata;
    end
  end

endmodule

// File: tb/tb_dotmtx_seq.sv
// Bench for dotmtx_seq: directed playback scenarios against a small AXI4-Lite slave,
// with a write scoreboard fed by the stimulus and drained by an independent monitor.
module tb_dotmtx_seq;

  localparam logic [31:0] BASE = 32'h4000_0010;
  localparam int unsigned PER  = 20;
  localparam logic [63:0] NEW1 = 64'hdead_beef_cafe_f00d;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  nframes_cfg = 4'd0;
  logic        fb_we = 1'b0;
  logic [2:0]  fb_addr = 3'd0;
  logic [63:0] fb_wdata = 64'd0;
  logic        busy;
  logic [2:0]  cur_frame;
  logic        err;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready;
  logic        m_axi_awready = 1'b0;
  logic        m_axi_wready = 1'b0;
  logic        m_axi_bvalid = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic [31:0] m_axi_awaddr, m_axi_wdata;
  logic [2:0]  m_axi_awprot;
  logic [3:0]  m_axi_wstrb;

  dotmtx_seq #(
    .BASE_ADDR(BASE),
    .NFRAMES  (8),
    .PERIOD   (PER)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .en           (en),
    .nframes_cfg  (nframes_cfg),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_wdata     (fb_wdata),
    .busy         (busy),
    .cur_frame    (cur_frame),
    .err          (err),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awprot (m_axi_awprot),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wstrb  (m_axi_wstrb),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .m_axi_bresp  (m_axi_bresp)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  frame;
  } exp_t;

  exp_t        q[$];
  logic [63:0] fr [8];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          aw_stall = 0;
  bit          inj_hi = 1'b0;
  bit          per_chk = 1'b0;
  int          last_lo = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  // Slave: samples handshakes before the edge, updates its outputs 1ns after it.
  initial begin
    bit          aw_f, w_f, b_f, s_aw, s_w;
    logic [31:0] a_smp, s_addr;
    s_aw = 0;
    s_w  = 0;
    s_addr = '0;
    forever begin
      @(negedge aclk);
      aw_f  = m_axi_awvalid && m_axi_awready;
      w_f   = m_axi_wvalid && m_axi_wready;
      b_f   = m_axi_bvalid && m_axi_bready;
      a_smp = m_axi_awaddr;
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        m_axi_awready = 0;
        m_axi_wready  = 0;
        m_axi_bvalid  = 0;
        s_aw = 0;
        s_w  = 0;
      end else begin
        if (b_f) m_axi_bvalid = 0;
        if (aw_f) begin
          s_aw   = 1;
          s_addr = a_smp;
        end
        if (w_f) s_w = 1;
        if (s_aw && s_w) begin
          s_aw = 0;
          s_w  = 0;
          m_axi_bvalid = 1;
          m_axi_bresp  = 2'b00;
          if (inj_hi && s_addr == BASE + 32'd4) begin
            m_axi_bresp = 2'b10;
            inj_hi = 0;
          end
        end
        if (m_axi_awvalid && aw_stall > 0) begin
          m_axi_awready = 0;
          aw_stall--;
        end else begin
          m_axi_awready = 1;
        end
        m_axi_wready = 1;
      end
    end
  end

  // Monitor: pairs accepted AW and W beats and checks them against the scoreboard.
  initial begin
    bit          got_a, got_w, aw_hold, w_hold;
    logic [31:0] cap_a, cap_w, aw_prev, w_prev;
    exp_t        e;
    got_a = 0;
    got_w = 0;
    aw_hold = 0;
    w_hold = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        got_a = 0;
        got_w = 0;
        aw_hold = 0;
        w_hold = 0;
      end else begin
        if (aw_hold) begin
          check("aw_held_valid", m_axi_awvalid, 1'b1);
          check("aw_held_addr", m_axi_awaddr, aw_prev);
        end
        if (w_hold) begin
          check("w_held_valid", m_axi_wvalid, 1'b1);
          check("w_held_data", m_axi_wdata, w_prev);
        end
        aw_hold = m_axi_awvalid && !m_axi_awready;
        aw_prev = m_axi_awaddr;
        w_hold  = m_axi_wvalid && !m_axi_wready;
        w_prev  = m_axi_wdata;
        if (m_axi_bready) check("bready_while_valid", m_axi_awvalid || m_axi_wvalid, 1'b0);
        if (m_axi_awvalid && m_axi_awready) begin
          check("dup_aw", got_a, 1'b0);
          got_a = 1;
          cap_a = m_axi_awaddr;
          if (per_chk && m_axi_awaddr == BASE) begin
            if (last_lo >= 0) check("frame_period", cyc - last_lo, PER);
            last_lo = cyc;
          end
        end
        if (m_axi_wvalid && m_axi_wready) begin
          check("dup_w", got_w, 1'b0);
          got_w = 1;
          cap_w = m_axi_wdata;
        end
        if (got_a && got_w) begin
          got_a = 0;
          got_w = 0;
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %h data %h, expected none", cap_a, cap_w);
          end else begin
            e = q.pop_front();
            check("awaddr", cap_a, e.addr);
            check("wdata", cap_w, e.data);
            check("cur_frame", cur_frame, e.frame);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wr_store(input logic [2:0] a, input logic [63:0] d);
    fb_we = 1;
    fb_addr = a;
    fb_wdata = d;
    tick();
    fb_we = 0;
  endtask

  task automatic push_frame(input logic [2:0] k, input logic [63:0] d);
    q.push_back('{addr: BASE, data: d[31:0], frame: k});
    q.push_back('{addr: BASE + 32'd4, data: d[63:32], frame: k});
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    check("drain_left", q.size(), 0);
    q.delete();
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    check("idle_busy", busy, 1'b0);
  endtask

  task automatic run_stop(input int limit);
    en = 1;
    wait_drain(limit);
    en = 0;
    wait_idle(100);
  endtask

  task automatic wait_aw_neg();
    bit ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge aclk);
      if (m_axi_awvalid) begin
        ok = 1;
        break;
      end
    end
    check("awvalid_seen", ok, 1'b1);
  endtask

  task automatic wait_bready_neg();
    bit ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge aclk);
      if (m_axi_bready) begin
        ok = 1;
        break;
      end
    end
    check("bready_seen", ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fr[0] = 64'h0123_4567_89ab_cdef;
    fr[1] = 64'h1111_2222_3333_4444;
    fr[2] = 64'ha5a5_0000_5a5a_ffff;
    fr[3] = 64'h3333_0000_0000_3333;
    fr[4] = 64'h4444_0000_0000_4444;
    fr[5] = 64'h5555_0000_0000_5555;
    fr[6] = 64'h6666_0000_0000_6666;
    fr[7] = 64'h7777_0000_0000_7777;

    repeat (3) @(posedge aclk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_cur_frame", cur_frame, 3'd0);
    check("rst_awvalid", m_axi_awvalid, 1'b0);
    check("rst_wvalid", m_axi_wvalid, 1'b0);
    check("rst_bready", m_axi_bready, 1'b0);
    check("rst_awaddr", m_axi_awaddr, 32'd0);
    check("rst_wdata", m_axi_wdata, 32'd0);
    check("awprot", m_axi_awprot, 3'b000);
    check("wstrb", m_axi_wstrb, 4'b1111);
    aresetn = 1;
    tick();
    for (int k = 0; k < 8; k++) wr_store(3'(k), fr[k]);

    // L=1, repeated frame 0 every PER cycles.
    nframes_cfg = 4'd1;
    per_chk = 1;
    last_lo = -1;
    for (int k = 0; k < 3; k++) push_frame(3'd0, fr[0]);
    run_stop(500);

    // L=3: frames 0,1,2,0,1; idx ends at 2.
    nframes_cfg = 4'd3;
    last_lo = -1;
    push_frame(3'd0, fr[0]);
    push_frame(3'd1, fr[1]);
    push_frame(3'd2, fr[2]);
    push_frame(3'd0, fr[0]);
    push_frame(3'd1, fr[1]);
    run_stop(500);

    // cfg=0 means L=1: resumes at idx 2, then stays on frame 0.
    nframes_cfg = 4'd0;
    last_lo = -1;
    push_frame(3'd2, fr[2]);
    push_frame(3'd0, fr[0]);
    push_frame(3'd0, fr[0]);
    run_stop(500);

    // cfg=15 clamps to 8 frames: 0..7 then wraps to 0.
    nframes_cfg = 4'd15;
    last_lo = -1;
    for (int k = 0; k < 8; k++) push_frame(3'(k), fr[k]);
    push_frame(3'd0, fr[0]);
    run_stop(1000);
    per_chk = 0;

    // AW stalled 5 cycles with W immediate; idx is 1 here, L=2 plays 1,0.
    nframes_cfg = 4'd2;
    aw_stall = 5;
    push_frame(3'd1, fr[1]);
    push_frame(3'd0, fr[0]);
    en = 1;
    wait_aw_neg();
    check("stall_wvalid_first", m_axi_wvalid, 1'b1);
    @(negedge aclk);
    check("stall_wvalid_drop", m_axi_wvalid, 1'b0);
    check("stall_awvalid_held", m_axi_awvalid, 1'b1);
    check("stall_bready_low", m_axi_bready, 1'b0);
    check("stall_awaddr", m_axi_awaddr, BASE);
    wait_drain(500);
    en = 0;
    wait_idle(100);

    // SLVERR on the high word of frame 1; frame 0 still follows, err stays set.
    check("err_before", err, 1'b0);
    inj_hi = 1;
    push_frame(3'd1, fr[1]);
    push_frame(3'd0, fr[0]);
    run_stop(500);
    check("err_sticky", err, 1'b1);

    // en dropped in B_LO: frame 1 completes, then idle; re-raise plays frame 0.
    push_frame(3'd1, fr[1]);
    en = 1;
    wait_bready_neg();
    en = 0;
    wait_drain(200);
    wait_idle(100);
    push_frame(3'd0, fr[0]);
    en = 1;
    for (int n = 0; n < 50 && !busy; n++) tick();
    en = 0;
    wait_drain(200);
    wait_idle(100);

    // Store write to the in-flight frame during WR_LO: new data only next pass.
    push_frame(3'd1, fr[1]);
    push_frame(3'd0, fr[0]);
    push_frame(3'd1, NEW1);
    en = 1;
    wait_aw_neg();
    fb_we = 1;
    fb_addr = 3'd1;
    fb_wdata = NEW1;
    @(negedge aclk);
    fb_we = 0;
    wait_drain(500);
    en = 0;
    wait_idle(100);

    // Async reset in the middle of WR_LO.
    en = 1;
    for (int n = 0; n < 50 && !busy; n++) tick();
    tick();
    check("pre_rst_awvalid", m_axi_awvalid, 1'b1);
    aresetn = 0;
    en = 0;
    #1;
    check("mid_rst_awvalid", m_axi_awvalid, 1'b0);
    check("mid_rst_wvalid", m_axi_wvalid, 1'b0);
    check("mid_rst_bready", m_axi_bready, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_awaddr", m_axi_awaddr, 32'd0);
    check("mid_rst_wdata", m_axi_wdata, 32'd0);
    repeat (2) tick();
    aresetn = 1;
    repeat (5) tick();
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_awvalid", m_axi_awvalid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dotmtx_seq.md
# dotmtx_seq

Autonomous frame sequencer for the 8x8 dot-matrix peripheral. It holds a small frame store of 64-bit frames and plays them back in a loop. On each frame tick it issues two AXI4-Lite writes to the dot-matrix peripheral: low word at BASE_ADDR, high word at BASE_ADDR+4. It sits on the peripheral bus as an additional master, ahead of the bus arbiter, so the CPU can start an animation and leave it running.

## Interface
Clocking: one clock; reset is asynchronous and active-low (`aclk`, `aresetn`).

Parameters:
- `BASE_ADDR`, 32'h0000_0000: byte address of the dot-matrix peripheral's low data word.
- `NFRAMES`, 8: frame store depth, power of two, ≥2.
- `PERIOD`, 1_000_000: `aclk` cycles between frame starts.

Ports:
- `aclk`  in  1  clock
- `aresetn`  in  1  async active-low reset
- `en`  in  1  playback enable (level)
- `nframes_cfg`  in  $clog2(NFRAMES)+1  frames in loop
- `fb_we`  in  1  frame store write strobe
- `fb_addr`  in  $clog2(NFRAMES)  frame store index
- `fb_wdata`  in  64  frame data (byte k = column k)
- `busy`  out  1  FSM not in IDLE
- `cur_frame`  out  $clog2(NFRAMES)  index of last frame issued
- `err`  out  1  sticky: any non-OKAY bresp since reset
- `m_axi_awvalid`  out  1
- `m_axi_awready`  in  1
- `m_axi_awaddr`  out  32
- `m_axi_awprot`  out  3  constant 3'b000
- `m_axi_wvalid`  out  1
- `m_axi_wready`  in  1
- `m_axi_wdata`  out  32
- `m_axi_wstrb`  out  4  constant 4'b1111
- `m_axi_bvalid`  in  1
- `m_axi_bready`  out  1
- `m_axi_bresp`  in  2

The block has no read channel; the interconnect ties off AR/R for this master.

## Operation
- Frame store: NFRAMES×64 flops, written synchronously when `fb_we`=1. Reset contents are 0. The store is not readable over the bus.
- Effective loop length `L`: `nframes_cfg`=0 gives 1; `nframes_cfg`>NFRAMES gives NFRAMES.
- FSM states: IDLE, LOAD, WR_LO, B_LO, WR_HI, B_HI, WAIT.
- IDLE → LOAD when `en`=1.
- LOAD: copies `store[idx]` into a 64-bit shadow register, sets `cur_frame`=idx, clears the period counter, and goes to WR_LO.
- WR_LO: drives awaddr=BASE_ADDR and wdata=shadow[31:0]. `awvalid` and `wvalid` rise in the same cycle. Each one drops independently on its own ready. When both have been accepted, go to B_LO.
- B_LO: `bready`=1. On bvalid, go to WR_HI.
- WR_HI and B_HI: same as WR_LO and B_LO, with addr BASE_ADDR+4 and shadow[63:32].
- B_HI → WAIT on bvalid. idx ← (idx+1 ≥ L) ? 0 : idx+1.
- WAIT: when counter = PERIOD−1, go to LOAD if `en`=1, else IDLE. If `en`=0 earlier, go to IDLE immediately.
- A frame in flight always completes both halves. `en` is sampled only in IDLE and WAIT.
- `err` is set on any bvalid with bresp≠0. Sequencing continues.
- idx is not reset by `en` falling. Playback resumes at the next frame.

## Timing
- Reset values: all AXI valid/ready outputs 0; awaddr 0; wdata 0; idx 0; `cur_frame` 0; `busy` 0; `err` 0; counter 0; state IDLE.
- `en` rising in IDLE: LOAD next cycle, awvalid/wvalid asserted the cycle after.
- With an always-ready slave whose bvalid follows one cycle after acceptance: about 6 cycles per frame. Frame start to frame start is exactly PERIOD cycles when PERIOD > transfer time. Otherwise frames run back-to-back.
- AXI rules:
  - A valid, once asserted, is held with stable addr/data until the handshake.
  - No valid depends combinationally on a ready.
  - At most one outstanding write.
- `fb_we` to frame idx while that frame is in flight affects only the next playback of that frame, because the shadow was latched in LOAD.
- `fb_we` in the same cycle as LOAD of the same index: LOAD sees the old data.
- Async reset mid-transfer: all outputs return to reset values immediately, with no completion of the transfer. The bus fabric is reset together with this block.

## Structure
- Shared package holds the state encoding constants, AXI response codes (OKAY=2'b00), and the hi/lo word offset (4).
- No sub-module is required. Optionally, `axil_wr_single` factors the single-beat AW/W/B handshake and is instantiated once, with address and data muxed by half.

## Test plan
- Reset, then en=1, L=1, store[0]=64'h0123456789abcdef, PERIOD=20, ready slave → repeated writes: (BASE, 32'h89abcdef) then (BASE+4, 32'h01234567), one pair every 20 cycles.
- L=3 with distinct frames → cur_frame sequence 0,1,2,0,1; nframes_cfg=0 → only frame 0; nframes_cfg=15 → wraps at NFRAMES.
- Slave holding awready low for 5 cycles while wready is immediate → wvalid drops after 1 cycle, awvalid held with stable addr, bready not asserted until both accepted.
- bresp=2'b10 on the high-word write → err=1 and sticky; next frame still issued.
- en dropped during B_LO → WR_HI/B_HI still complete, then IDLE with busy=0; en re-raised → next frame index issued.
- fb_we to the in-flight frame index during WR_LO → high word is the old data; the next loop pass shows the new data.
